alarm_set_ctrl: RTL and testbench

//  Command generator for the four alarm digit registers (HH:MM). Turns debounced

---
 rtl/alarm_set_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_alarm_set_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_set_ctrl.sv
// Command generator for the HH:MM alarm digit registers: digit selection,
// wrap limits, 23-hour clamp, key auto-repeat and edit-mode timeout.
module alarm_set_ctrl #(
  parameter int CNT_W      = 29,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000,
  parameter int TIMEOUT    = 500_000_000
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        key_set,
  input  logic        key_up,
  input  logic        key_down,
  input  logic [3:0]  dig_mu,
  input  logic [3:0]  dig_mt,
  input  logic [3:0]  dig_hu,
  input  logic [3:0]  dig_ht,
  output logic [3:0]  cmd_add,
  output logic [3:0]  cmd_sub,
  output logic [3:0]  cmd_clear,
  output logic [19:0] cmd_reset,
  output logic [3:0]  cmd_keep,
  output logic        edit_active,
  output logic [1:0]  edit_sel
);

  typedef enum logic [2:0] {IDLE, E_HT, E_HU, E_MT, E_MU} state_t;

  localparam logic [4:0] CODE_NONE = 5'b00001;
  localparam logic [4:0] CODE_9    = 5'b00010;
  localparam logic [4:0] CODE_5    = 5'b00100;
  localparam logic [4:0] CODE_3    = 5'b01000;
  localparam logic [4:0] CODE_2    = 5'b10000;

  localparam logic [CNT_W-1:0] DLY_C   = CNT_W'(REPEAT_DLY);
  localparam logic [CNT_W-1:0] PER_C   = CNT_W'(REPEAT_PER);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state, state_next;

  logic [2:0]       key_q, key_q2;
  logic [CNT_W-1:0] rep_cnt, to_cnt;
  logic             first_step;

  logic up_lvl, down_lvl, up_rise, down_rise, set_rise;
  logic held, press, repeat_hit, step_raw, step, inhibit;
  logic key_change, timeout_hit, ht_to_2;

  logic [1:0]  sel_idx, sel_d;
  logic [3:0]  add_d, sub_d, clear_d, keep_d;
  logic [19:0] reset_d;

  logic [3:0] dig   [4];
  logic [3:0] max_v [4];
  logic [4:0] code_v[4];

  assign dig[0] = dig_mu;
  assign dig[1] = dig_mt;
  assign dig[2] = dig_hu;
  assign dig[3] = dig_ht;

  // Hour units wrap at 3 only while the hour tens already reads 2
  assign max_v[0]  = 4'd9;
  assign max_v[1]  = 4'd5;
  assign max_v[2]  = (dig_ht == 4'd2) ? 4'd3 : 4'd9;
  assign max_v[3]  = 4'd2;
  assign code_v[0] = CODE_9;
  assign code_v[1] = CODE_5;
  assign code_v[2] = (dig_ht == 4'd2) ? CODE_3 : CODE_9;
  assign code_v[3] = CODE_2;

  assign up_lvl     = key_q[0];
  assign down_lvl   = key_q[1];
  assign up_rise    = key_q[0] & ~key_q2[0];
  assign down_rise  = key_q[1] & ~key_q2[1];
  assign set_rise   = key_q[2] & ~key_q2[2];
  assign held       = up_lvl ^ down_lvl;
  assign press      = (up_rise & ~down_lvl) | (down_rise & ~up_lvl);
  assign repeat_hit = held && (rep_cnt == (first_step ? DLY_C : PER_C));
  assign step_raw   = press | repeat_hit;
  // Any strobe still on the outputs means the digit feedback is stale
  assign inhibit    = ~&cmd_keep;
  assign step       = step_raw & ~inhibit & (state != IDLE);
  assign key_change = |(key_q ^ key_q2);
  assign timeout_hit = (state != IDLE) && (to_cnt == TO_LAST) && !key_change && !step_raw;
  assign ht_to_2    = up_lvl ? (dig_ht == 4'd1) : ((dig_ht == 4'd0) || (dig_ht > 4'd2));

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      key_q  <= '0;
      key_q2 <= '0;
    end else begin
      key_q  <= {key_set, key_down, key_up};
      key_q2 <= key_q;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      rep_cnt    <= '0;
      first_step <= 1'b1;
      to_cnt     <= '0;
    end else begin
      if (!held) begin
        rep_cnt    <= '0;
        first_step <= 1'b1;
      end else if (press) begin
        rep_cnt    <= CNT_ONE;
        first_step <= 1'b1;
      end else if (repeat_hit) begin
        rep_cnt    <= CNT_ONE;
        first_step <= 1'b0;
      end else begin
        rep_cnt <= rep_cnt + CNT_ONE;
      end
      if (state == IDLE || key_change || step_raw) to_cnt <= '0;
      else                                         to_cnt <= to_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_add     <= '0;
      cmd_sub     <= '0;
      cmd_clear   <= '0;
      cmd_reset   <= {4{CODE_NONE}};
      cmd_keep    <= 4'hF;
      edit_active <= 1'b0;
      edit_sel    <= 2'd3;
    end else begin
      state       <= state_next;
      cmd_add     <= add_d;
      cmd_sub     <= sub_d;
      cmd_clear   <= clear_d;
      cmd_reset   <= reset_d;
      cmd_keep    <= keep_d;
      edit_active <= (state_next != IDLE);
      edit_sel    <= sel_d;
    end
  end

  always_comb begin
    state_next = state;
    if (set_rise) begin
      case (state)
        IDLE:    state_next = E_HT;
        E_HT:    state_next = E_HU;
        E_HU:    state_next = E_MT;
        E_MT:    state_next = E_MU;
        default: state_next = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    case (state)
      E_HT:    sel_idx = 2'd3;
      E_HU:    sel_idx = 2'd2;
      E_MT:    sel_idx = 2'd1;
      E_MU:    sel_idx = 2'd0;
      default: sel_idx = edit_sel;
    endcase
    case (state_next)
      E_HT:    sel_d = 2'd3;
      E_HU:    sel_d = 2'd2;
      E_MT:    sel_d = 2'd1;
      E_MU:    sel_d = 2'd0;
      default: sel_d = edit_sel;
    endcase

    add_d   = '0;
    sub_d   = '0;
    clear_d = '0;
    reset_d = {4{CODE_NONE}};
    keep_d  = '1;
    for (int i = 0; i < 4; i++) begin
      if (step && sel_idx == 2'(i)) begin
        if (up_lvl) begin
          if (dig[i] >= max_v[i]) clear_d[i] = 1'b1;
          else                    add_d[i]   = 1'b1;
        end else if (dig[i] == 4'd0 || dig[i] > max_v[i]) begin
          reset_d[5*i +: 5] = code_v[i];
        end else begin
          sub_d[i] = 1'b1;
        end
      end
    end
    // Landing hour tens on 2 with hour units above 3 would give an invalid hour
    if (step && sel_idx == 2'd3 && ht_to_2 && dig_hu > 4'd3) reset_d[14:10] = CODE_3;
    for (int i = 0; i < 4; i++)
      keep_d[i] = ~(add_d[i] | sub_d[i] | clear_d[i] | (reset_d[5*i +: 5] != CODE_NONE));
  end

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Scoreboard bench for alarm_set_ctrl: directed key sequences push expected
// strobes; a negedge monitor pops and compares every strobe the DUT emits.
module tb_alarm_set_ctrl;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        key_set, key_up, key_down;
  logic [3:0]  dig_mu, dig_mt, dig_hu, dig_ht;
  logic [3:0]  cmd_add, cmd_sub, cmd_clear, cmd_keep;
  logic [19:0] cmd_reset;
  logic        edit_active;
  logic [1:0]  edit_sel;

  localparam logic [4:0] N  = 5'b00001;
  localparam logic [4:0] C9 = 5'b00010;
  localparam logic [4:0] C5 = 5'b00100;
  localparam logic [4:0] C3 = 5'b01000;
  localparam logic [4:0] C2 = 5'b10000;

  typedef struct {
    logic [3:0]  e_add;
    logic [3:0]  e_sub;
    logic [3:0]  e_clr;
    logic [19:0] e_rst;
    logic [3:0]  e_keep;
    int          e_cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   t0;

  alarm_set_ctrl #(
    .CNT_W(29), .REPEAT_DLY(8), .REPEAT_PER(3), .TIMEOUT(50)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n),
    .key_set(key_set), .key_up(key_up), .key_down(key_down),
    .dig_mu(dig_mu), .dig_mt(dig_mt), .dig_hu(dig_hu), .dig_ht(dig_ht),
    .cmd_add(cmd_add), .cmd_sub(cmd_sub), .cmd_clear(cmd_clear),
    .cmd_reset(cmd_reset), .cmd_keep(cmd_keep),
    .edit_active(edit_active), .edit_sel(edit_sel)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  function automatic logic [19:0] mk_rst(input logic [4:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic u, input logic d, input int cycles);
    key_set  = s;
    key_up   = u;
    key_down = d;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [3:0] s, input logic [3:0] c,
                          input logic [19:0] r, input logic [3:0] k, input int at);
    exp_t e;
    e.e_add = a; e.e_sub = s; e.e_clr = c; e.e_rst = r; e.e_keep = k; e.e_cyc = at;
    sb.push_back(e);
  endtask

  task automatic pulse_key(input logic u, input logic d);
    applyStimulus(1'b0, u, d, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4);
  endtask

  task automatic press_set();
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
  endtask

  // Any non-idle command vector is a strobe that must match the queue head
  always @(negedge sysclk) begin
    exp_t e;
    if (rst_n === 1'b1 &&
        ((cmd_add | cmd_sub | cmd_clear) != 4'd0 || cmd_reset != 20'h08421 || cmd_keep != 4'hF)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_strobe: add=%h sub=%h clr=%h rst=%h keep=%h at cycle %0d, expected none",
                 cmd_add, cmd_sub, cmd_clear, cmd_reset, cmd_keep, cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("strobe_add_sub_clr_keep", {16'd0, cmd_add, cmd_sub, cmd_clear, cmd_keep},
                    {16'd0, e.e_add, e.e_sub, e.e_clr, e.e_keep});
        checkOutput("strobe_reset", {12'd0, cmd_reset}, {12'd0, e.e_rst});
        checkOutput("strobe_cycle", cyc, e.e_cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    key_set = 0; key_up = 0; key_down = 0;
    dig_mu = 0; dig_mt = 0; dig_hu = 0; dig_ht = 0;
    tick(); tick();
    checkOutput("reset_cmd_reset", {12'd0, cmd_reset}, 32'h08421);
    checkOutput("reset_keep", cmd_keep, 4'hF);
    checkOutput("reset_add_sub_clr", {cmd_add, cmd_sub, cmd_clear}, 12'h000);
    checkOutput("reset_edit_active", edit_active, 1'b0);
    checkOutput("reset_edit_sel", edit_sel, 2'd3);
    rst_n = 1'b1;
    tick(); tick();

    press_set();
    checkOutput("sel_ht_active", edit_active, 1'b1);
    checkOutput("sel_ht", edit_sel, 2'd3);

    dig_ht = 1; dig_hu = 7; t0 = cyc;
    push_exp(4'b1000, 4'b0, 4'b0, mk_rst(N, C3, N, N), 4'b0011, t0 + 2);
    pulse_key(1, 0);
    dig_ht = 2; dig_hu = 3; t0 = cyc;
    push_exp(4'b0, 4'b0, 4'b1000, mk_rst(N, N, N, N), 4'b0111, t0 + 2);
    pulse_key(1, 0);
    dig_ht = 0; dig_hu = 5; t0 = cyc;
    push_exp(4'b0, 4'b0, 4'b0, mk_rst(C2, C3, N, N), 4'b0011, t0 + 2);
    pulse_key(0, 1);
    dig_ht = 2; dig_hu = 0; t0 = cyc;
    push_exp(4'b0, 4'b1000, 4'b0, mk_rst(N, N, N, N), 4'b0111, t0 + 2);
    pulse_key(0, 1);

    press_set();
    checkOutput("sel_hu", edit_sel, 2'd2);
    dig_ht = 2; dig_hu = 3; t0 = cyc;
    push_exp(4'b0, 4'b0, 4'b0100, mk_rst(N, N, N, N), 4'b1011, t0 + 2);
    pulse_key(1, 0);
    dig_ht = 2; dig_hu = 0; t0 = cyc;
    push_exp(4'b0, 4'b0, 4'b0, mk_rst(N, C3, N, N), 4'b1011, t0 + 2);
    pulse_key(0, 1);

    dig_ht = 1; dig_hu = 4; t0 = cyc;
    push_exp(4'b0100, 4'b0, 4'b0, mk_rst(N, N, N, N), 4'b1011, t0 + 2);
    push_exp(4'b0100, 4'b0, 4'b0, mk_rst(N, N, N, N), 4'b1011, t0 + 10);
    push_exp(4'b0100, 4'b0, 4'b0, mk_rst(N, N, N, N), 4'b1011, t0 + 13);
    push_exp(4'b0100, 4'b0, 4'b0, mk_rst(N, N, N, N), 4'b1011, t0 + 16);
    push_exp(4'b0100, 4'b0, 4'b0, mk_rst(N, N, N, N), 4'b1011, t0 + 19);
    applyStimulus(1'b0, 1'b1, 1'b0, 20);
    applyStimulus(1'b0, 1'b0, 1'b0, 5);

    press_set();
    checkOutput("sel_mt", edit_sel, 2'd1);
    dig_mt = 0; t0 = cyc;
    push_exp(4'b0, 4'b0, 4'b0, mk_rst(N, N, C5, N), 4'b1101, t0 + 2);
    pulse_key(0, 1);
    dig_mt = 7; t0 = cyc;
    push_exp(4'b0, 4'b0, 4'b0, mk_rst(N, N, C5, N), 4'b1101, t0 + 2);
    pulse_key(0, 1);
    dig_mt = 3; t0 = cyc;
    push_exp(4'b0010, 4'b0, 4'b0, mk_rst(N, N, N, N), 4'b1101, t0 + 2);
    pulse_key(1, 0);

    press_set();
    checkOutput("sel_mu", edit_sel, 2'd0);
    dig_mu = 9; t0 = cyc;
    push_exp(4'b0, 4'b0, 4'b0001, mk_rst(N, N, N, N), 4'b1110, t0 + 2);
    pulse_key(1, 0);
    dig_mu = 4; t0 = cyc;
    push_exp(4'b0001, 4'b0, 4'b0, mk_rst(N, N, N, N), 4'b1110, t0 + 2);
    pulse_key(1, 0);
    dig_mu = 0; t0 = cyc;
    push_exp(4'b0, 4'b0, 4'b0, mk_rst(N, N, N, C9), 4'b1110, t0 + 2);
    pulse_key(0, 1);
    dig_mu = 5; t0 = cyc;
    push_exp(4'b0, 4'b0001, 4'b0, mk_rst(N, N, N, N), 4'b1110, t0 + 2);
    pulse_key(0, 1);

    // A down press landing in the settle cycle after a strobe is dropped
    dig_mu = 4; t0 = cyc;
    push_exp(4'b0001, 4'b0, 4'b0, mk_rst(N, N, N, N), 4'b1110, t0 + 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5);

    applyStimulus(1'b0, 1'b1, 1'b1, 12);
    applyStimulus(1'b0, 1'b0, 1'b0, 30);
    checkOutput("timeout_not_early_30", edit_active, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 15);
    checkOutput("timeout_not_early_45", edit_active, 1'b1);
    for (int w = 0; w < 40 && edit_active; w++) tick();
    checkOutput("timeout_exit", edit_active, 1'b0);
    checkOutput("idle_sel_held", edit_sel, 2'd0);

    pulse_key(1, 0);
    checkOutput("idle_keys_ignored", edit_active, 1'b0);

    press_set();
    checkOutput("reenter_sel_ht", edit_sel, 2'd3);
    dig_ht = 1; dig_hu = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    rst_n = 1'b0;
    tick();
    checkOutput("midreset_active", edit_active, 1'b0);
    checkOutput("midreset_sel", edit_sel, 2'd3);
    checkOutput("midreset_reset", {12'd0, cmd_reset}, 32'h08421);
    checkOutput("midreset_keep", cmd_keep, 4'hF);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 6);

    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
